// File: rtl/pipeline_exec_pkg.sv
// Shared command bytes and FSM state encoding for the pipeline execution controller.
package pipeline_exec_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_CONT = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_LEN,
        ST_LOAD_BYTE,
        ST_LOAD_WRITE,
        ST_FLUSH,
        ST_RUN,
        ST_STEP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/pipeline_exec_controller_word_assembler.sv
// Packs incoming UART bytes, MSB first, into one instruction word.
module word_assembler #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_shift,
    input  logic [7:0]       i_byte,
    output logic [WIDTH-1:0] o_word,
    output logic [1:0]       o_byte_cnt,
    output logic             o_word_valid
);

    logic [WIDTH-1:0] r_word;
    logic [1:0]       r_cnt;
    logic             r_valid;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_word  <= '0;
            r_cnt   <= 2'd0;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_word  <= '0;
            r_cnt   <= 2'd0;
            r_valid <= 1'b0;
        end else if (i_shift) begin
            r_word  <= {r_word[WIDTH-9:0], i_byte};
            r_cnt   <= r_cnt + 2'd1;
            // Valid stays up until the next byte of the following word arrives.
            r_valid <= (r_cnt == 2'd3);
        end
    end

    assign o_word       = r_word;
    assign o_byte_cnt   = r_cnt;
    assign o_word_valid = r_valid;

endmodule

// File: rtl/pipeline_exec_controller.sv
// Byte-driven sequencer that loads instruction memory, flushes the core and
// gates the shared pipeline enable for continuous runs or single steps.
module pipeline_exec_controller
    import pipeline_exec_pkg::*;
#(
    parameter int SIZE            = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_INSTRUCTION = 64,
    parameter int CNT_WIDTH       = 32,
    parameter int WATCHDOG        = 2**20
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    input  logic [7:0]            i_cmd,
    output logic                  o_cmd_ready,
    input  logic                  i_halt,
    output logic                  o_pipe_enable,
    output logic                  o_pipe_flush,
    output logic                  o_inst_write_enable,
    output logic [ADDR_WIDTH-1:0] o_write_addr,
    output logic [SIZE-1:0]       o_write_data,
    output logic                  o_step_mode,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [CNT_WIDTH-1:0]  o_cycle_count
);

    localparam int WD_W = $clog2(WATCHDOG + 1);

    state_t               r_state;
    state_t               w_next;
    logic [7:0]           r_len;
    logic [7:0]           r_index;
    logic                 r_err;
    logic                 r_halted;
    logic                 r_step_mode;
    logic [CNT_WIDTH-1:0] r_cycle_count;
    logic [WD_W-1:0]      r_wd;

    logic                 w_ready;
    logic                 w_enable;
    logic                 w_flush;
    logic                 w_we;
    logic                 w_done;
    logic                 w_accept;
    logic                 w_len_bad;
    logic                 w_wd_last;
    logic                 w_asm_clear;
    logic                 w_asm_shift;
    logic [SIZE-1:0]      w_word;
    logic [1:0]           w_byte_cnt;
    logic                 w_word_valid;

    assign w_accept    = i_cmd_valid & w_ready;
    assign w_len_bad   = (i_cmd == 8'd0) || ({24'd0, i_cmd} > MAX_INSTRUCTION);
    assign w_wd_last   = (r_wd == WD_W'(WATCHDOG - 1));
    assign w_asm_clear = (r_state == ST_IDLE) && i_cmd_valid && (i_cmd == CMD_LOAD);
    assign w_asm_shift = (r_state == ST_LOAD_BYTE) && i_cmd_valid;

    word_assembler #(
        .WIDTH(SIZE)
    ) u_word_assembler (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (w_asm_clear),
        .i_shift     (w_asm_shift),
        .i_byte      (i_cmd),
        .o_word      (w_word),
        .o_byte_cnt  (w_byte_cnt),
        .o_word_valid(w_word_valid)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_ready  = 1'b0;
        w_enable = 1'b0;
        w_flush  = 1'b0;
        w_we     = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (i_cmd_valid) begin
                    if (i_cmd == CMD_LOAD) begin
                        w_next = ST_LOAD_LEN;
                    end else if (i_cmd == CMD_CONT) begin
                        w_next = r_halted ? ST_DONE : ST_RUN;
                    end else if (i_cmd == CMD_STEP) begin
                        w_next = ST_STEP;
                    end
                end
            end
            ST_LOAD_LEN: begin
                w_ready = 1'b1;
                if (i_cmd_valid) begin
                    w_next = w_len_bad ? ST_IDLE : ST_LOAD_BYTE;
                end
            end
            ST_LOAD_BYTE: begin
                w_ready = 1'b1;
                if (i_cmd_valid && (w_byte_cnt == 2'd3)) begin
                    w_next = ST_LOAD_WRITE;
                end
            end
            ST_LOAD_WRITE: begin
                w_we   = w_word_valid;
                w_next = (r_index == r_len - 8'd1) ? ST_FLUSH : ST_LOAD_BYTE;
            end
            ST_FLUSH: begin
                w_flush = 1'b1;
                w_next  = ST_IDLE;
            end
            ST_RUN: begin
                // Enable drops in the same cycle HALT appears so it stays frozen in MEM/WB.
                w_enable = !i_halt;
                if (i_halt || w_wd_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_STEP: begin
                w_enable = !i_halt;
                w_next   = ST_DONE;
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_len         <= 8'd0;
            r_index       <= 8'd0;
            r_err         <= 1'b0;
            r_halted      <= 1'b0;
            r_step_mode   <= 1'b0;
            r_cycle_count <= '0;
            r_wd          <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && (i_cmd == CMD_CONT)) begin
                        r_step_mode <= 1'b0;
                        r_wd        <= '0;
                    end else if (w_accept && (i_cmd == CMD_STEP)) begin
                        r_step_mode <= 1'b1;
                    end
                end
                ST_LOAD_LEN: begin
                    if (w_accept) begin
                        if (w_len_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_err   <= 1'b0;
                            r_len   <= i_cmd;
                            r_index <= 8'd0;
                        end
                    end
                end
                ST_LOAD_WRITE: begin
                    r_index <= r_index + 8'd1;
                end
                ST_FLUSH: begin
                    r_cycle_count <= '0;
                    r_halted      <= 1'b0;
                end
                ST_RUN: begin
                    if (i_halt) begin
                        r_halted <= 1'b1;
                    end else begin
                        r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
                        r_wd          <= r_wd + WD_W'(1);
                        if (w_wd_last) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_STEP: begin
                    if (i_halt) begin
                        r_halted <= 1'b1;
                    end else begin
                        r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_cmd_ready         = w_ready;
    assign o_pipe_enable       = w_enable;
    assign o_pipe_flush        = w_flush;
    assign o_inst_write_enable = w_we;
    assign o_write_addr        = ADDR_WIDTH'({r_index, 2'b00});
    assign o_write_data        = w_word;
    assign o_step_mode         = r_step_mode;
    assign o_busy              = (r_state != ST_IDLE);
    assign o_done              = w_done;
    assign o_err               = r_err;
    assign o_cycle_count       = r_cycle_count;

endmodule
